// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encodings (tx and rx).
// Default bit-time and width constants live here so both directions agree.
package uart_pkg;

    localparam int DEF_WIDTH_DATA = 8;
    localparam int DEF_NB_STOP    = 2;
    localparam int DEF_CLK_SIZE   = 434;
    localparam int DEF_WIDTH_CLK  = 9;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_WIDTH_PTR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO, WIDTH_DATA x FIFO_DEPTH, with full/empty/count.
// A push into a full FIFO is taken only when a pop happens the same cycle.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH_PTR  = DEF_WIDTH_PTR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH_DATA-1:0] i_data,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [WIDTH_PTR:0]    o_count
);

    localparam logic [WIDTH_PTR:0] DEPTH_C = (WIDTH_PTR+1)'(FIFO_DEPTH);

    logic [WIDTH_DATA-1:0] mem_q [FIFO_DEPTH];
    logic [WIDTH_PTR-1:0]  wptr_q, wptr_d;
    logic [WIDTH_PTR-1:0]  rptr_q, rptr_d;
    logic [WIDTH_PTR:0]    cnt_q, cnt_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign o_full  = (cnt_q == DEPTH_C);
    assign o_empty = (cnt_q == '0);
    assign o_count = cnt_q;
    assign o_data  = mem_q[rptr_q];
    assign pop_ok  = i_pop && !o_empty;
    assign push_ok = i_push && (!o_full || pop_ok);

    // Pointer and occupancy next-state; pointers wrap naturally.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + WIDTH_PTR'(1);
        if (pop_ok)  rptr_d = rptr_q + WIDTH_PTR'(1);
        cnt_d = cnt_q + (WIDTH_PTR+1)'(push_ok) - (WIDTH_PTR+1)'(pop_ok);
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wptr_q] <= i_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter, start + data LSB-first + stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int WIDTH_DATA = DEF_WIDTH_DATA,
    parameter int NB_STOP    = DEF_NB_STOP,
    parameter int CLK_SIZE   = DEF_CLK_SIZE,
    parameter int WIDTH_CLK  = DEF_WIDTH_CLK,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH_PTR  = DEF_WIDTH_PTR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [WIDTH_DATA-1:0] i_data,
    output logic                  o_full,
    output logic                  o_mty,
    output logic                  o_busy,
    output logic                  o_tx
);

    localparam int BIT_MAX = (WIDTH_DATA > NB_STOP) ? WIDTH_DATA : NB_STOP;
    localparam int BIT_W   = $clog2(BIT_MAX + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(WIDTH_DATA - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(NB_STOP - 1);
    localparam logic [WIDTH_CLK-1:0] TICK_AT = WIDTH_CLK'(CLK_SIZE - 1);

    uart_state_e           state_q, state_d;
    logic [WIDTH_CLK-1:0]  cnt_q, cnt_d;
    logic [WIDTH_DATA-1:0] sr_q, sr_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_d;
`endif
    logic                  pop;
    logic                  tick;
    logic                  f_empty;
    logic [WIDTH_DATA-1:0] f_data;
    logic [WIDTH_PTR:0]    f_count;

    uart_fifo #(
        .WIDTH_DATA (WIDTH_DATA),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH_PTR  (WIDTH_PTR)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_we),
        .i_pop   (pop),
        .i_data  (i_data),
        .o_data  (f_data),
        .o_full  (o_full),
        .o_empty (f_empty),
        .o_count (f_count)
    );

    assign tick   = (cnt_q == TICK_AT);
    assign o_tx   = tx_q;
    assign o_busy = (state_q != ST_IDLE);
    assign o_mty  = (f_count == '0) && (state_q == ST_IDLE);

    // Frame sequencer and baud counter next-state; a frame is loaded
    // from the FIFO either from IDLE or straight out of the last stop bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != ST_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + WIDTH_CLK'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (!f_empty) begin
                    pop     = 1'b1;
                    sr_d    = f_data;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^f_data;
`endif
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d    = sr_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = ST_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
`endif
                    end else begin
                        sr_d  = sr_q >> 1;
                        tx_d  = sr_d[0];
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (!f_empty) begin
                            pop     = 1'b1;
                            sr_d    = f_data;
                            tx_d    = 1'b0;
                            state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                            par_d   = ^f_data;
`endif
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Sequencer state, shifter, baud counter and registered line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench for uart_tx_buffered.
// Honours UART_TX_PARITY_EN to expect the parity bit in each frame.
module tb_uart_tx_buffered;

    localparam int WD = 8;
    localparam int NS = 2;
    localparam int CS = 4;
    localparam int WC = 2;
    localparam int FD = 4;
    localparam int WP = 2;
`ifdef UART_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FRAME = (1 + WD + NPAR + NS) * CS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [WD-1:0] data = '0;
    logic          full;
    logic          mty;
    logic          busy;
    logic          tx;

    uart_tx_buffered #(
        .WIDTH_DATA (WD),
        .NB_STOP    (NS),
        .CLK_SIZE   (CS),
        .WIDTH_CLK  (WC),
        .FIFO_DEPTH (FD),
        .WIDTH_PTR  (WP)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_we   (we),
        .i_data (data),
        .o_full (full),
        .o_mty  (mty),
        .o_busy (busy),
        .o_tx   (tx)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [WD-1:0] sb_q[$];

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(logic [WD-1:0] b, int idx);
        if (idx == 0) return 1'b0;
        if (idx <= WD) return b[idx-1];
        if (NPAR == 1 && idx == WD + 1) return ^b;
        return 1'b1;
    endfunction

    // Line monitor: decodes frames and checks every cycle of every bit.
    int            cyc = 0;
    int            mon_pos = 0;
    int            mon_frames = 0;
    int            last_end = -10;
    bit            mon_act = 1'b0;
    bit            gap_en = 1'b0;
    logic [WD-1:0] mon_byte = '0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                if (gap_en && mon_frames > 0)
                    chk("frame_gap", 32'(cyc - last_end - 1), 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    mon_byte = '0;
                end else begin
                    mon_byte = sb_q.pop_front();
                end
                mon_act = 1'b1;
                mon_pos = 0;
            end
        end else begin
            mon_pos++;
            chk($sformatf("tx_bit byte=%02h pos=%0d", mon_byte, mon_pos),
                32'(tx), 32'(exp_bit(mon_byte, mon_pos / CS)));
            if (mon_pos == FRAME - 1) begin
                mon_act = 1'b0;
                mon_frames++;
                last_end = cyc;
            end
        end
    end

    task automatic wr(logic [WD-1:0] b, bit exp_acc);
        we = 1'b1;
        data = b;
        if (exp_acc) sb_q.push_back(b);
        @(posedge clk);
        #1 we = 1'b0;
    endtask

    task automatic wait_frames(int n, int budget);
        int k = 0;
        while (mon_frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", 32'(mon_frames), 32'(n));
    endtask

    task automatic drained(string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 0);
        chk({tag, "_mty"}, 32'(mty), 1);
        chk({tag, "_tx_idle"}, 32'(tx), 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_mty", 32'(mty), 1);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // single byte: latency and frame length
        mon_frames = 0;
        wr(8'hA5, 1'b1);
        @(negedge clk);
        chk("lat_tx_e0", 32'(tx), 1);
        chk("lat_mty_e0", 32'(mty), 0);
        @(negedge clk);
        chk("lat_tx_e1", 32'(tx), 0);
        chk("lat_busy_e1", 32'(busy), 1);
        repeat (43) @(negedge clk);
        chk("mty_before_end", 32'(mty), 0);
        @(negedge clk);
        chk("mty_at_end", 32'(mty), 1);
        chk("busy_at_end", 32'(busy), 0);
        chk("frames_a5", 32'(mon_frames), 1);
        drained("a5");

        // back-to-back frames with no idle gap
        mon_frames = 0;
        gap_en = 1'b1;
        wr(8'h01, 1'b1);
        wr(8'h02, 1'b1);
        wr(8'h03, 1'b1);
        wait_frames(3, 3 * FRAME + 20);
        gap_en = 1'b0;
        drained("b2b");

        // overflow: sixth consecutive write dropped
        mon_frames = 0;
        wr(8'h10, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h12, 1'b1);
        wr(8'h13, 1'b1);
        wr(8'h14, 1'b1);
        @(negedge clk);
        chk("ovf_full", 32'(full), 1);
        wr(8'h15, 1'b0);
        wait_frames(5, 5 * FRAME + 40);
        repeat (FRAME) @(negedge clk);
        chk("ovf_frames_exact", 32'(mon_frames), 5);
        drained("ovf");

        // write while full on the cycle the stop bit pops
        mon_frames = 0;
        wr(8'h20, 1'b1);
        wr(8'h21, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h23, 1'b1);
        wr(8'h24, 1'b1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("fp_full_before", 32'(full), 1);
        chk("fp_last_stop", 32'(tx), 1);
        wr(8'h25, 1'b1);
        @(negedge clk);
        chk("fp_full_after", 32'(full), 1);
        chk("fp_next_start", 32'(tx), 0);
        wait_frames(6, 6 * FRAME + 40);
        drained("fp");

        // reset in the middle of a frame discards everything
        mon_frames = 0;
        wr(8'hFF, 1'b1);
        wr(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(tx), 1);
        chk("rst_mid_mty", 32'(mty), 1);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_full", 32'(full), 0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        chk("rst_mid_frames", 32'(mon_frames), 0);
        drained("rst_mid");

        // parity values and mixed patterns
        mon_frames = 0;
        wr(8'h07, 1'b1);
        wr(8'h03, 1'b1);
        wr(8'h80, 1'b1);
        wait_frames(3, 3 * FRAME + 20);
        drained("par");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
